// File: rtl/sensor_pkg.sv
// Shared command/response codes and state encodings for the sensor
// scheduler, UART framing and top-level glue.
package sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DHT,
    ST_RESPOND,
    ST_GUARD
  } state_t;

  typedef enum logic [1:0] {
    REQ_STATUS,
    REQ_TEMP,
    REQ_HUM
  } req_t;

  localparam logic [7:0] CMD_STATUS   = 8'h00;
  localparam logic [7:0] CMD_TEMP     = 8'h01;
  localparam logic [7:0] CMD_HUM      = 8'h02;
  localparam logic [7:0] CMD_SET_TEMP = 8'h03;
  localparam logic [7:0] CMD_SET_HUM  = 8'h04;
  localparam logic [7:0] CMD_CLR_TEMP = 8'h05;
  localparam logic [7:0] CMD_CLR_HUM  = 8'h06;

  localparam logic [7:0] RSP_STATUS   = 8'h07;
  localparam logic [7:0] RSP_HUM      = 8'h08;
  localparam logic [7:0] RSP_TEMP     = 8'h09;
  localparam logic [7:0] RSP_CLR_TEMP = 8'h0A;
  localparam logic [7:0] RSP_CLR_HUM  = 8'h0B;
  localparam logic [7:0] RSP_SET_TEMP = 8'h0C;
  localparam logic [7:0] RSP_SET_HUM  = 8'h0D;
  localparam logic [7:0] RSP_ERROR    = 8'h1F;
  localparam logic [7:0] RSP_BAD_CMD  = 8'hFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating down-counter: load a value, count down while enabled,
// expired is high once the count reaches zero.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sensor_scheduler.sv
// Arbitrates PC commands and round-robin continuous polling onto a single
// DHT reader, with a timeout per read and a guard interval between reads.
module sensor_scheduler
  import sensor_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  input  logic [4:0] cmd_addr,
  output logic       cmd_ready,
  output logic       dht_start,
  output logic [4:0] dht_index,
  input  logic       dht_done,
  input  logic       dht_error,
  input  logic [7:0] temp_int,
  input  logic [7:0] hum_int,
  output logic       rsp_valid,
  output logic [7:0] rsp_cmd,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_value,
  input  logic       rsp_ready
);

  localparam int unsigned TMR_MAX = max_u(GUARD_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
  // Timer is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [TMR_W-1:0] GUARD_LOAD   = TMR_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] cont_temp_q, cont_temp_d;
  logic [31:0] cont_hum_q, cont_hum_d;
  logic [5:0]  scan_q, scan_d;
  logic [4:0]  dht_index_q, dht_index_d;
  logic        accessed_q, accessed_d;
  logic [7:0]  rsp_cmd_q, rsp_cmd_d;
  logic [7:0]  rsp_addr_q, rsp_addr_d;
  logic [7:0]  rsp_value_q, rsp_value_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_count;
  logic             tmr_expired;

  logic [4:0] scan_idx;
  logic       scan_hum;
  logic       slot_set;

  assign scan_idx = scan_q[5:1];
  assign scan_hum = scan_q[0];
  assign slot_set = scan_hum ? cont_hum_q[scan_idx] : cont_temp_q[scan_idx];

  cycle_timer #(.WIDTH(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .count      (tmr_count),
    .expired    (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cont_temp_d = cont_temp_q;
    cont_hum_d  = cont_hum_q;
    scan_d      = scan_q;
    dht_index_d = dht_index_q;
    accessed_d  = accessed_q;
    rsp_cmd_d   = rsp_cmd_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_value_d = rsp_value_q;
    tmr_load    = 1'b0;
    tmr_value   = GUARD_LOAD;
    tmr_count   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rsp_addr_d  = {3'b000, cmd_addr};
          rsp_value_d = 8'h00;
          accessed_d  = 1'b0;
          state_d     = ST_RESPOND;
          unique case (cmd_code)
            CMD_STATUS, CMD_TEMP, CMD_HUM: begin
              dht_index_d = cmd_addr;
              accessed_d  = 1'b1;
              state_d     = ST_START;
              req_d       = (cmd_code == CMD_STATUS) ? REQ_STATUS :
                            (cmd_code == CMD_TEMP)   ? REQ_TEMP : REQ_HUM;
            end
            CMD_SET_TEMP: begin
              cont_temp_d[cmd_addr] = 1'b1;
              rsp_cmd_d = RSP_SET_TEMP;
            end
            CMD_SET_HUM: begin
              cont_hum_d[cmd_addr] = 1'b1;
              rsp_cmd_d = RSP_SET_HUM;
            end
            CMD_CLR_TEMP: begin
              cont_temp_d[cmd_addr] = 1'b0;
              rsp_cmd_d = RSP_CLR_TEMP;
            end
            CMD_CLR_HUM: begin
              cont_hum_d[cmd_addr] = 1'b0;
              rsp_cmd_d = RSP_CLR_HUM;
            end
            default: rsp_cmd_d = RSP_BAD_CMD;
          endcase
        end else begin
          scan_d = scan_q + 6'd1;
          if (slot_set) begin
            dht_index_d = scan_idx;
            req_d       = scan_hum ? REQ_HUM : REQ_TEMP;
            accessed_d  = 1'b1;
            state_d     = ST_START;
          end
        end
      end

      ST_START: begin
        tmr_load  = 1'b1;
        tmr_value = TIMEOUT_LOAD;
        state_d   = ST_WAIT_DHT;
      end

      ST_WAIT_DHT: begin
        tmr_count = 1'b1;
        if (dht_done || tmr_expired) begin
          state_d     = ST_RESPOND;
          rsp_addr_d  = {3'b000, dht_index_q};
          rsp_cmd_d   = RSP_ERROR;
          rsp_value_d = 8'h00;
          if (dht_done && !dht_error) begin
            unique case (req_q)
              REQ_TEMP: begin
                rsp_cmd_d   = RSP_TEMP;
                rsp_value_d = temp_int;
              end
              REQ_HUM: begin
                rsp_cmd_d   = RSP_HUM;
                rsp_value_d = hum_int;
              end
              default: rsp_cmd_d = RSP_STATUS;
            endcase
          end
        end
      end

      ST_RESPOND: begin
        if (rsp_ready) begin
          if (accessed_q) begin
            tmr_load  = 1'b1;
            tmr_value = GUARD_LOAD;
            state_d   = ST_GUARD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GUARD: begin
        tmr_count = 1'b1;
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= REQ_STATUS;
      cont_temp_q <= '0;
      cont_hum_q  <= '0;
      scan_q      <= '0;
      dht_index_q <= '0;
      accessed_q  <= 1'b0;
      rsp_cmd_q   <= '0;
      rsp_addr_q  <= '0;
      rsp_value_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cont_temp_q <= cont_temp_d;
      cont_hum_q  <= cont_hum_d;
      scan_q      <= scan_d;
      dht_index_q <= dht_index_d;
      accessed_q  <= accessed_d;
      rsp_cmd_q   <= rsp_cmd_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_value_q <= rsp_value_d;
    end
  end

  // Handshake outputs are gated so they read zero while rst is held.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign dht_start = (state_q == ST_START) && !rst;
  assign rsp_valid = (state_q == ST_RESPOND) && !rst;
  assign dht_index = dht_index_q;
  assign rsp_cmd   = rsp_cmd_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_value = rsp_value_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler: command table plus hand-written
// sequences for polling, guard, timeout, back-pressure and reset.
module tb_sensor_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code = '0;
  logic [4:0] cmd_addr = '0;
  logic       cmd_ready;
  logic       dht_start;
  logic [4:0] dht_index;
  logic       dht_done = 1'b0;
  logic       dht_error = 1'b0;
  logic [7:0] temp_int = '0;
  logic [7:0] hum_int = '0;
  logic       rsp_valid;
  logic [7:0] rsp_cmd, rsp_addr, rsp_value;
  logic       rsp_ready = 1'b0;

  int nchecks = 0;
  int nerr = 0;
  int starts = 0;
  bit auto_dht = 1'b0;

  sensor_scheduler #(.GUARD_CYCLES(100), .TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_addr  (cmd_addr),
    .cmd_ready (cmd_ready),
    .dht_start (dht_start),
    .dht_index (dht_index),
    .dht_done  (dht_done),
    .dht_error (dht_error),
    .temp_int  (temp_int),
    .hum_int   (hum_int),
    .rsp_valid (rsp_valid),
    .rsp_cmd   (rsp_cmd),
    .rsp_addr  (rsp_addr),
    .rsp_value (rsp_value),
    .rsp_ready (rsp_ready)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (dht_start === 1'b1) starts++;

  // Sensor model: answers 3 cycles after a start, temp 0x20+idx, hum 0x40+idx.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_dht && dht_start === 1'b1) begin
        repeat (3) @(negedge clk);
        dht_done  = 1'b1;
        dht_error = 1'b0;
        temp_int  = 8'h20 + {3'b000, dht_index};
        hum_int   = 8'h40 + {3'b000, dht_index};
        @(negedge clk);
        dht_done  = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({name, "_dht_start"}, {31'd0, dht_start}, 32'd0);
    chk({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({name, "_dht_index"}, {27'd0, dht_index}, 32'd0);
    chk({name, "_rsp_frame"}, {8'd0, rsp_cmd, rsp_addr, rsp_value}, 32'd0);
  endtask

  task automatic issue(input logic [7:0] code, input logic [4:0] addr);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_addr  = addr;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("issue_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_frame(input int hold, output logic [7:0] c, output logic [7:0] a,
                            output logic [7:0] v, output int waited, output bit ok);
    bit stable;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    ok = (rsp_valid === 1'b1);
    c = rsp_cmd;
    a = rsp_addr;
    v = rsp_value;
    if (!ok) begin
      chk("frame_timeout", {31'd0, rsp_valid}, 32'd1);
    end else begin
      if (hold > 0) begin
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          if (rsp_valid !== 1'b1 || rsp_cmd !== c || rsp_addr !== a || rsp_value !== v)
            stable = 1'b0;
        end
        chk("frame_stable_backpressure", {31'd0, stable}, 32'd1);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] ec, input logic [7:0] ea,
                              input logic [7:0] ev, input int hold);
    logic [7:0] c, a, v;
    int w;
    bit ok;
    wait_frame(hold, c, a, v, w, ok);
    if (ok) chk(name, {8'd0, c, a, v}, {8'd0, ec, ea, ev});
  endtask

  task automatic wait_start(input string name, output bit ok);
    int n;
    @(negedge clk);
    n = 0;
    while (dht_start !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = (dht_start === 1'b1);
    if (!ok) chk({name, "_start_timeout"}, {31'd0, dht_start}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] code;
    logic [4:0] addr;
    logic [7:0] exp_cmd;
    logic [7:0] exp_val;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] c, a, v, prev_c;
    int w, s0, n;
    bit ok, quiet;

    vecs[0] = '{8'h03, 5'd2,  8'h0C, 8'h00};
    vecs[1] = '{8'h05, 5'd2,  8'h0A, 8'h00};
    vecs[2] = '{8'h04, 5'd3,  8'h0D, 8'h00};
    vecs[3] = '{8'h06, 5'd3,  8'h0B, 8'h00};
    vecs[4] = '{8'h09, 5'd4,  8'hFF, 8'h00};
    vecs[5] = '{8'hFF, 5'd1,  8'hFF, 8'h00};
    vecs[6] = '{8'h07, 5'd31, 8'hFF, 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Config and unknown commands: answered directly, no sensor access
    foreach (vecs[i]) begin
      s0 = starts;
      issue(vecs[i].code, vecs[i].addr);
      expect_frame($sformatf("vec%0d_frame", i), vecs[i].exp_cmd,
                   {3'b000, vecs[i].addr}, vecs[i].exp_val, 0);
      chk($sformatf("vec%0d_no_start", i), starts - s0, 32'd0);
    end

    // Temperature read of sensor 5 followed by a 100-cycle guard
    s0 = starts;
    issue(8'h01, 5'd5);
    wait_start("temp5", ok);
    chk("temp5_index", {27'd0, dht_index}, 32'd5);
    @(negedge clk);
    @(negedge clk);
    dht_done = 1'b1;
    temp_int = 8'h19;
    hum_int  = 8'h77;
    @(negedge clk);
    dht_done = 1'b0;
    expect_frame("temp5_frame", 8'h09, 8'h05, 8'h19, 0);
    chk("temp5_one_start", starts - s0, 32'd1);
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1 || n > 1000) break;
      n++;
    end
    chk("guard_len", n, 32'd100);

    // Continuous polling of sensor 2, temperature and humidity alternate
    do_reset();
    auto_dht = 1'b1;
    issue(8'h03, 5'd2);
    expect_frame("set_t2", 8'h0C, 8'h02, 8'h00, 0);
    issue(8'h04, 5'd2);
    expect_frame("set_h2", 8'h0D, 8'h02, 8'h00, 0);
    prev_c = 8'h00;
    for (int k = 0; k < 4; k++) begin
      wait_frame(0, c, a, v, w, ok);
      if (ok) begin
        chk($sformatf("poll%0d_addr", k), {24'd0, a}, 32'h02);
        chk($sformatf("poll%0d_value", k), {24'd0, v},
            (c == 8'h09) ? 32'h22 : (c == 8'h08) ? 32'h42 : 32'hEEEE);
        if (k == 0) begin
          chk("poll0_kind", {31'd0, (c == 8'h08 || c == 8'h09)}, 32'd1);
        end else begin
          chk($sformatf("poll%0d_alternate", k), {24'd0, c}, (prev_c == 8'h09) ? 32'h08 : 32'h09);
          chk($sformatf("poll%0d_guard_gap", k), {31'd0, (w >= 100)}, 32'd1);
        end
        prev_c = c;
      end
    end
    s0 = starts;
    issue(8'h05, 5'd2);
    expect_frame("clr_t2", 8'h0A, 8'h02, 8'h00, 0);
    issue(8'h06, 5'd2);
    expect_frame("clr_h2", 8'h0B, 8'h02, 8'h00, 0);
    chk("clr_no_start", starts - s0, 32'd0);
    auto_dht = 1'b0;

    // Status read with sensor error
    issue(8'h00, 5'd7);
    wait_start("status7", ok);
    chk("status7_index", {27'd0, dht_index}, 32'd7);
    @(negedge clk);
    dht_done  = 1'b1;
    dht_error = 1'b1;
    @(negedge clk);
    dht_done  = 1'b0;
    dht_error = 1'b0;
    expect_frame("status7_err", 8'h1F, 8'h07, 8'h00, 0);

    // Stray dht_done during guard is ignored
    @(negedge clk);
    dht_done = 1'b1;
    @(negedge clk);
    dht_done = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    chk("stray_done_ignored", {31'd0, quiet}, 32'd1);

    // Humidity read with no answer times out
    issue(8'h02, 5'd3);
    wait_start("hum3", ok);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("hum3_timeout_latency", {31'd0, (n >= 50 && n <= 52)}, 32'd1);
    expect_frame("hum3_timeout", 8'h1F, 8'h03, 8'h00, 0);

    // Polling bits 0 and 31 with a command arriving during the guard
    do_reset();
    auto_dht = 1'b1;
    issue(8'h03, 5'd0);
    expect_frame("set_t0", 8'h0C, 8'h00, 8'h00, 0);
    expect_frame("scan_t0_first", 8'h09, 8'h00, 8'h20, 0);
    s0 = starts;
    issue(8'h03, 5'd31);
    expect_frame("guard_cmd_first", 8'h0C, 8'h1F, 8'h00, 0);
    chk("guard_cmd_no_start", starts - s0, 32'd0);
    expect_frame("scan_t31", 8'h09, 8'h1F, 8'h3F, 0);
    expect_frame("scan_t0_wrap", 8'h09, 8'h00, 8'h20, 20);
    auto_dht = 1'b0;

    // Reset during WAIT_DHT abandons the access and clears the tables
    wait_start("rst_access", ok);
    chk("rst_access_index", {27'd0, dht_index}, 32'd31);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_no_start", {31'd0, dht_start}, 32'd0);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    s0 = starts;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    chk("post_rst_no_rsp", {31'd0, quiet}, 32'd1);
    chk("post_rst_tables_clear", starts - s0, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
